pair_stim_driver: RTL and testbench

//  Clocked stimulus driver for an a/b signal pair: the producing end of the pair that the

---
 rtl/pair_stim_driver_if.sv | 13 +
 rtl/pair_stim_driver.sv | 144 ++++++++++++++
 tb/tb_pair_stim_driver.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/pair_stim_driver_if.sv
// Command port of pair_stim_driver: one (a, b, hold) entry per valid/ready transfer.
interface pair_stim_driver_if #(
  parameter int HOLD_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_a;
  logic              cmd_b;
  logic [HOLD_W-1:0] cmd_hold;

  modport master (output cmd_valid, cmd_a, cmd_b, cmd_hold, input cmd_ready);
  modport slave  (input cmd_valid, cmd_a, cmd_b, cmd_hold, output cmd_ready);
endinterface

// File: rtl/pair_stim_driver.sv
// Buffered a/b pair driver: plays queued (a, b, hold) entries back-to-back on registered a/b.
// Optional build macro PAIR_DRV_TRACE_EN adds simulation trace of a/b changes and stalled commands.
module pair_stim_driver #(
  parameter int DEPTH  = 4,
  parameter int HOLD_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  pair_stim_driver_if.slave cmd,
  output logic              a,
  output logic              b,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, DRIVE} state_t;

  typedef struct packed {
    logic              a;
    logic              b;
    logic [HOLD_W-1:0] hold;
  } entry_t;

  entry_t            mem [DEPTH];
  entry_t            head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [HOLD_W-1:0] rem;
  logic [HOLD_W-1:0] head_hold;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              finish;
  logic              last_cycle;
  state_t            state;
  state_t            state_nxt;

  // Readiness depends on full only, so a pop in the same cycle never frees a slot early.
  assign full          = (count == (AW+1)'(DEPTH));
  assign empty         = (count == '0);
  assign cmd.cmd_ready = !full && !rst;
  assign push          = cmd.cmd_valid && cmd.cmd_ready;
  assign head          = mem[rd_ptr];
  assign head_hold     = (head.hold == '0) ? HOLD_W'(1) : head.hold;
  assign last_cycle    = (rem <= HOLD_W'(1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = DRIVE;
      DRIVE:   if (last_cycle && empty) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Decisions use the FIFO contents before the edge; a same-edge push is seen next cycle.
  always_comb begin
    pop    = 1'b0;
    finish = 1'b0;
    busy   = (state == DRIVE);
    case (state)
      IDLE:  pop = !empty;
      DRIVE: begin
        if (last_cycle) begin
          pop    = !empty;
          finish = empty;
        end
      end
      default: ;
    endcase
  end

  // NOTE: the entry storage has no reset; the pointers and count alone define which slots are valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{a: cmd.cmd_a, b: cmd.cmd_b, hold: cmd.cmd_hold};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rem    <= '0;
      a      <= 1'b0;
      b      <= 1'b0;
      done   <= 1'b0;
      issued <= '0;
    end else begin
      done <= finish;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
        a      <= head.a;
        b      <= head.b;
        rem    <= head_hold;
        issued <= issued + CNT_W'(1);
      end else if (state == DRIVE && !last_cycle) begin
        rem <= rem - HOLD_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
    end
  end

`ifdef PAIR_DRV_TRACE_EN
  logic a_nxt;
  logic b_nxt;

  always_comb begin
    a_nxt = a;
    b_nxt = b;
    if (rst) begin
      a_nxt = 1'b0;
      b_nxt = 1'b0;
    end else if (pop) begin
      a_nxt = head.a;
      b_nxt = head.b;
    end
  end

  always @(posedge clk) begin
    if (a_nxt != a || b_nxt != b)
      $display("%t a=%b b=%b", $time, a_nxt, b_nxt);
    if (cmd.cmd_valid && !cmd.cmd_ready)
      $display("%t pair_stim_driver warning: cmd_valid high while cmd_ready low", $time);
  end
`endif

endmodule

// File: tb/tb_pair_stim_driver.sv
// Self-checking bench for pair_stim_driver: directed cycle table, corner sequences, random vs queue model.
module tb_pair_stim_driver;
  localparam int DEPTH  = 4;
  localparam int HOLD_W = 8;
  localparam int CNT_W  = 16;

  typedef struct {
    bit a;
    bit b;
    int hold;
  } cmd_t;

  typedef struct {
    bit r;
    bit v;
    bit ca;
    bit cb;
    int h;
    bit e_ready;
    bit e_a;
    bit e_b;
    bit e_busy;
    bit e_done;
    int e_iss;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             a;
  logic             b;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] issued;

  pair_stim_driver_if #(.HOLD_W(HOLD_W)) cmd_if ();

  pair_stim_driver #(.DEPTH(DEPTH), .HOLD_W(HOLD_W), .CNT_W(CNT_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .cmd    (cmd_if),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .issued (issued)
  );

  always #5 clk = ~clk;

  // Reference model: a queue of pending commands plus the entry currently on a/b.
  cmd_t             q[$];
  bit               m_a, m_b, m_busy, m_done;
  int               m_rem;
  logic [CNT_W-1:0] m_iss;

  int n_cmp = 0;
  int n_bad = 0;

  vec_t vecs[21];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input bit r, input bit v, input bit ca, input bit cb, input int h);
    @(negedge clk);
    rst              = r;
    cmd_if.cmd_valid = v;
    cmd_if.cmd_a     = ca;
    cmd_if.cmd_b     = cb;
    cmd_if.cmd_hold  = h[HOLD_W-1:0];
    #1;
  endtask

  // Advance the model by one clock edge using the inputs currently applied.
  task automatic model_edge();
    bit   accept;
    cmd_t e;
    accept = !rst && cmd_if.cmd_valid && (q.size() < DEPTH);
    if (rst) begin
      q.delete();
      m_a = 0; m_b = 0; m_busy = 0; m_done = 0; m_rem = 0; m_iss = '0;
      return;
    end
    m_done = 0;
    if (!m_busy || m_rem == 1) begin
      if (q.size() > 0) begin
        e      = q.pop_front();
        m_a    = e.a;
        m_b    = e.b;
        m_rem  = (e.hold == 0) ? 1 : e.hold;
        m_iss  = m_iss + 1'b1;
        m_busy = 1;
      end else if (m_busy) begin
        m_busy = 0;
        m_done = 1;
      end
    end else begin
      m_rem--;
    end
    if (accept) begin
      e.a    = cmd_if.cmd_a;
      e.b    = cmd_if.cmd_b;
      e.hold = int'(cmd_if.cmd_hold);
      q.push_back(e);
    end
  endtask

  task automatic check_model();
    check("cmd_ready", 32'(cmd_if.cmd_ready), 32'(!rst && (q.size() < DEPTH)));
    check("a",         32'(a),      32'(m_a));
    check("b",         32'(b),      32'(m_b));
    check("busy",      32'(busy),   32'(m_busy));
    check("done",      32'(done),   32'(m_done));
    check("issued",    32'(issued), 32'(m_iss));
  endtask

  task automatic cycle(input bit r, input bit v, input bit ca, input bit cb, input int h);
    apply(r, v, ca, cb, h);
    check_model();
    model_edge();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  waits;
    bit  got;
    bit  r, v;
    int  h;

    //           r v a b h   rdy a b bsy dn iss
    vecs[0]  = '{0,1,1,0,3,  1,0,0,0,0,0};
    vecs[1]  = '{0,0,0,0,0,  1,0,0,0,0,0};
    vecs[2]  = '{0,0,0,0,0,  1,1,0,1,0,1};
    vecs[3]  = '{0,0,0,0,0,  1,1,0,1,0,1};
    vecs[4]  = '{0,0,0,0,0,  1,1,0,1,0,1};
    vecs[5]  = '{0,0,0,0,0,  1,1,0,0,1,1};
    vecs[6]  = '{0,1,1,1,2,  1,1,0,0,0,1};
    vecs[7]  = '{0,1,0,1,1,  1,1,0,0,0,1};
    vecs[8]  = '{0,1,0,0,4,  1,1,1,1,0,2};
    vecs[9]  = '{0,0,0,0,0,  1,1,1,1,0,2};
    vecs[10] = '{0,0,0,0,0,  1,0,1,1,0,3};
    vecs[11] = '{0,0,0,0,0,  1,0,0,1,0,4};
    vecs[12] = '{0,0,0,0,0,  1,0,0,1,0,4};
    vecs[13] = '{0,0,0,0,0,  1,0,0,1,0,4};
    vecs[14] = '{0,0,0,0,0,  1,0,0,1,0,4};
    vecs[15] = '{0,0,0,0,0,  1,0,0,0,1,4};
    vecs[16] = '{0,1,1,1,0,  1,0,0,0,0,4};
    vecs[17] = '{0,0,0,0,0,  1,0,0,0,0,4};
    vecs[18] = '{0,0,0,0,0,  1,1,1,1,0,5};
    vecs[19] = '{0,0,0,0,0,  1,1,1,0,1,5};
    vecs[20] = '{0,0,0,0,0,  1,1,1,0,0,5};

    rst = 1'b1;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_a     = 1'b0;
    cmd_if.cmd_b     = 1'b0;
    cmd_if.cmd_hold  = '0;

    // Two reset edges, then the directed cycle table (single entry, back-to-back, hold=0).
    apply(1, 0, 0, 0, 0); model_edge();
    apply(1, 0, 0, 0, 0); model_edge();
    for (int i = 0; i < 21; i++) begin
      apply(vecs[i].r, vecs[i].v, vecs[i].ca, vecs[i].cb, vecs[i].h);
      check($sformatf("vec%0d_ready", i),  32'(cmd_if.cmd_ready), 32'(vecs[i].e_ready));
      check($sformatf("vec%0d_a", i),      32'(a),      32'(vecs[i].e_a));
      check($sformatf("vec%0d_b", i),      32'(b),      32'(vecs[i].e_b));
      check($sformatf("vec%0d_busy", i),   32'(busy),   32'(vecs[i].e_busy));
      check($sformatf("vec%0d_done", i),   32'(done),   32'(vecs[i].e_done));
      check($sformatf("vec%0d_issued", i), 32'(issued), 32'(vecs[i].e_iss));
      model_edge();
    end

    // FIFO fills behind a long entry; the fifth push waits for the first pop.
    cycle(0, 1, 1, 1, 200);
    for (int i = 0; i < 4; i++) cycle(0, 1, i[0], 1, i + 1);
    waits = 0;
    got   = 0;
    for (int i = 0; i < 300 && !got; i++) begin
      cycle(0, 1, 0, 0, 7);
      if (cmd_if.cmd_ready) got = 1;
      else                  waits++;
    end
    check("full_wait_cycles", 32'(waits), 32'd197);
    for (int i = 0; i < 100 && (m_busy || q.size() > 0); i++) cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);

    // Reset while the second of three buffered entries is on a/b.
    cycle(0, 1, 1, 0, 3);
    cycle(0, 1, 0, 1, 3);
    cycle(0, 1, 1, 1, 3);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    check("rst_mid_ab", 32'({a, b}), 32'b01);
    cycle(0, 0, 0, 0, 0);
    check("rst_after_ab",     32'({a, b, busy, done}), 32'b0000);
    check("rst_after_issued", 32'(issued), 32'd0);
    check("rst_after_ready",  32'(cmd_if.cmd_ready), 32'd1);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      check("rst_no_done", 32'(done), 32'd0);
    end

    // Push lands on the last DRIVE cycle with the FIFO empty: done, one idle cycle, then the entry.
    cycle(0, 1, 1, 0, 2);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 1);
    check("late_push_busy", 32'(busy), 32'd1);
    cycle(0, 0, 0, 0, 0);
    check("late_push_gap", 32'({a, b, busy, done}), 32'b1001);
    cycle(0, 0, 0, 0, 0);
    check("late_push_new", 32'({a, b, busy, done}), 32'b0110);
    check("late_push_issued", 32'(issued), 32'd2);

    // Random traffic against the queue model.
    for (int i = 0; i < 600; i++) begin
      r = ($urandom_range(0, 99) == 0);
      v = $urandom_range(0, 1) == 1;
      h = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6));
      cycle(r, v, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, h);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
